// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, reads one instruction at a time and hands it to the decoder over valid/ready.
// Define HALT_DETECT_EN to add the halted output and a terminal HALT state for opcode 3'b111.
module instruction_fetch #(
    parameter int              PC_W     = 9,
    parameter int              INSN_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_rd,
    output logic [PC_W-1:0]   mem_addr,
    input  logic [INSN_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [INSN_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [PC_W-1:0]   pc_ir,
    input  logic              redirect_en,
    input  logic [PC_W-1:0]   redirect_pc
`ifdef HALT_DETECT_EN
    ,
    output logic              halted
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN
`ifdef HALT_DETECT_EN
        ,
        S_HALT
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc_ir_q, pc_ir_d;
    logic [INSN_W-1:0] ir_q, ir_d;
    logic              vld_q, vld_d;
    logic              redirect_ok;

`ifdef HALT_DETECT_EN
    logic halted_q, halted_d;
    assign redirect_ok = redirect_en && (state_q != S_IDLE) && (state_q != S_HALT);
`else
    assign redirect_ok = redirect_en && (state_q != S_IDLE);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc_ir_d = pc_ir_q;
        ir_d    = ir_q;
        vld_d   = vld_q;
`ifdef HALT_DETECT_EN
        halted_d = halted_q;
`endif
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_rvalid) begin
                    ir_d    = mem_rdata;
                    pc_ir_d = pc_q;
                    pc_d    = pc_q + PC_W'(1);
                    vld_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ir_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_FETCH;
`ifdef HALT_DETECT_EN
                    if (ir_q[INSN_W-1 -: 3] == 3'b111) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
`endif
                end
            end
            S_DRAIN: if (mem_rvalid) state_d = S_FETCH;
`ifdef HALT_DETECT_EN
            S_HALT:  state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over everything; in DRAIN the outstanding response still has to be swallowed.
        if (redirect_ok) begin
            pc_d    = redirect_pc;
            vld_d   = 1'b0;
            ir_d    = ir_q;
            pc_ir_d = pc_ir_q;
`ifdef HALT_DETECT_EN
            halted_d = halted_q;
`endif
            if (state_q == S_WAIT)
                state_d = mem_rvalid ? S_FETCH : S_DRAIN;
            else if (state_q != S_DRAIN)
                state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            pc_ir_q <= '0;
            ir_q    <= '0;
            vld_q   <= 1'b0;
`ifdef HALT_DETECT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc_ir_q <= pc_ir_d;
            ir_q    <= ir_d;
            vld_q   <= vld_d;
`ifdef HALT_DETECT_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign mem_rd   = (state_q == S_FETCH);
    assign mem_addr = mem_rd ? pc_q : '0;
    assign ir_out   = ir_q;
    assign ir_valid = vld_q;
    assign pc_ir    = pc_ir_q;
`ifdef HALT_DETECT_EN
    assign halted   = halted_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic against a transaction-level model.
// The memory responder answers one outstanding read after a programmable latency.
module tb_instruction_fetch;
    localparam int PC_W   = 9;
    localparam int INSN_W = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              mem_rd;
    logic [PC_W-1:0]   mem_addr;
    logic [INSN_W-1:0] mem_rdata = '0;
    logic              mem_rvalid = 1'b0;
    logic [INSN_W-1:0] ir_out;
    logic              ir_valid;
    logic              ir_ready = 1'b0;
    logic [PC_W-1:0]   pc_ir;
    logic              redirect_en = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
`ifdef HALT_DETECT_EN
    logic              halted;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(.PC_W(PC_W), .INSN_W(INSN_W), .RESET_PC(9'd0)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready), .pc_ir(pc_ir),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc)
`ifdef HALT_DETECT_EN
        , .halted(halted)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem [512];

    // Model: architectural PC, the instruction expected in the IR, and the read in flight.
    logic [8:0]  m_pc, m_pcir, m_req, resp_addr;
    logic [15:0] m_ir;
    bit          m_valid, m_busy, m_sq, m_idle, m_halt;
    int          cnt, lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 9'd0; m_pcir = '0; m_req = '0; m_ir = '0;
        m_valid = 0; m_busy = 0; m_sq = 0; m_idle = 1; m_halt = 0;
        cnt = 0;
    endtask

    // Called at a negedge: async reset mid-cycle, check reset outputs, release at a later negedge.
    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        mem_rvalid = 1'b0; redirect_en = 1'b0; ir_ready = 1'b0;
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ir_out", ir_out, 0);
        chk("rst_pc_ir", pc_ir, 0);
        chk("rst_ir_valid", ir_valid, 0);
`ifdef HALT_DETECT_EN
        chk("rst_halted", halted, 0);
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model to the next edge.
    task automatic tick(input bit red_i, input logic [8:0] rpc, input bit rdy, input bit frv);
        bit rv, red, exp_rd;
        exp_rd = !m_idle && !m_busy && !m_valid && !m_halt;
        chk("ir_valid", ir_valid, m_valid);
        if (m_valid) begin
            chk("ir_out", ir_out, m_ir);
            chk("pc_ir", pc_ir, m_pcir);
        end
        chk("mem_rd", mem_rd, exp_rd);
        chk("mem_addr", mem_addr, exp_rd ? m_pc : 9'd0);
`ifdef HALT_DETECT_EN
        chk("halted", halted, m_halt);
`endif
        rv = 0;
        if (mem_rd) begin
            m_busy = 1; m_sq = 0; m_req = m_pc; resp_addr = mem_addr; cnt = lat;
        end else if (m_busy) begin
            cnt--;
            rv = (cnt == 0);
        end else begin
            rv = frv;
        end
        // A redirect during FETCH would leave two reads in flight; the responder models only one.
        red = red_i && !mem_rd;
        mem_rvalid  = rv;
        mem_rdata   = (rv && m_busy) ? mem[resp_addr] : 16'($urandom);
        redirect_en = red;
        redirect_pc = rpc;
        ir_ready    = rdy;

        if (!m_idle && !m_halt) begin
            if (red) begin
                if (m_busy && !rv) m_sq = 1;
                m_pc = rpc;
                m_valid = 0;
            end else if (rv && m_busy && !m_sq) begin
                m_valid = 1;
                m_ir    = mem[m_req];
                m_pcir  = m_req;
                m_pc    = m_req + 9'd1;
            end else if (m_valid && rdy) begin
                m_valid = 0;
`ifdef HALT_DETECT_EN
                if (m_ir[15:13] == 3'b111) m_halt = 1;
`endif
            end
        end
        if (rv) m_busy = 0;
        m_idle = 0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = 16'($urandom);
`ifdef HALT_DETECT_EN
            if (mem[i][15:13] == 3'b111) mem[i][13] = 1'b0;
`endif
        end
        mem[0]      = 16'hD105;
        mem[9'h1FF] = 16'h1234;
        model_reset();
        lat = 1;
        @(negedge clk);

        // Reset and first fetch with a 1-cycle memory
        do_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("first_ir_valid", ir_valid, 1);
        chk("first_ir_out", ir_out, 16'hD105);
        chk("first_pc_ir", pc_ir, 0);

        // Backpressure
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
        chk("bp_ir_out", ir_out, 16'hD105);
        chk("bp_mem_rd", mem_rd, 0);
        tick(0, 0, 1, 0);
        chk("bp_next_rd", mem_rd, 1);
        chk("bp_next_addr", mem_addr, 1);

        // Redirect in WAIT, squashed response arrives later
        lat = 3;
        tick(0, 0, 0, 0);
        tick(1, 9'h040, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("drain_valid", ir_valid, 0);
        chk("drain_addr", mem_addr, 9'h040);

        // Wrap from 0x1FF to 0x000
        lat = 1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 9'h1FF, 0, 0);
        chk("wrap_fetch", mem_addr, 9'h1FF);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("wrap_pc_ir", pc_ir, 9'h1FF);
        chk("wrap_ir_out", ir_out, 16'h1234);
        tick(0, 0, 1, 0);
        chk("wrap_next_addr", mem_addr, 0);
        chk("wrap_next_rd", mem_rd, 1);

        // ir_ready, redirect and response in the same cycle
        tick(0, 0, 0, 0);
        tick(1, 9'h123, 1, 0);
        chk("simul_valid", ir_valid, 0);
        chk("simul_addr", mem_addr, 9'h123);

        // Reset mid-WAIT then a stray late response
        lat = 3;
        tick(0, 0, 0, 0);
        do_reset();
        tick(0, 0, 1, 1);
        chk("post_rst_rd", mem_rd, 1);
        chk("post_rst_addr", mem_addr, 0);
        lat = 1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("post_rst_ir", ir_out, 16'hD105);

`ifdef HALT_DETECT_EN
        do_reset();
        mem[2] = 16'hE000;
        for (int i = 0; i < 40; i++) if (!m_halt) tick(0, 0, 1, 0);
        chk("halt_set", halted, 1);
        for (int i = 0; i < 20; i++) tick(1, 9'($urandom), 1, 0);
        chk("halt_hold_rd", mem_rd, 0);
        mem[2] = 16'h0002;
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (!m_busy) lat = $urandom_range(1, 4);
            tick(($urandom % 12) == 0, 9'($urandom), ($urandom % 3) != 0, ($urandom % 8) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
